// File: rtl/addsub_pkg.sv
// Types and forward add/sub model shared by the add/sub unit, its recovery block and their benches.
// Result width is always one bit wider than the operand width.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 8;

  typedef struct packed {
    logic [ADDSUB_WIDTH:0]   result;
    logic [ADDSUB_WIDTH-1:0] dataa;
    logic                    add_sub;
  } addsub_tuple_t;

  // Forward operation of the registered add/sub unit (add_sub=1 adds, 0 subtracts).
  function automatic logic [ADDSUB_WIDTH:0] addsub_fwd(
    input logic [ADDSUB_WIDTH-1:0] dataa,
    input logic [ADDSUB_WIDTH-1:0] datab,
    input logic                    add_sub
  );
    logic [ADDSUB_WIDTH:0] a_ext;
    logic [ADDSUB_WIDTH:0] b_ext;
    a_ext = {1'b0, dataa};
    b_ext = {1'b0, datab};
    return add_sub ? (a_ext + b_ext) : (a_ext - b_ext);
  endfunction

endpackage

// File: rtl/addsub_pipe_stage.sv
// Generic valid/ready register slice: 1-cycle latency, full throughput.
// Accepts when empty or when its own output is being taken this cycle; otherwise holds.
module addsub_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/addsub_operand_recover.sv
// Recovers datab from {result, dataa, add_sub} tuples and flags impossible ones.
// 2-cycle latency, 1 tuple/cycle; in_ready falls only when both stages are full and out_ready is low.
module addsub_operand_recover
  import addsub_pkg::*;
#(
  parameter int WIDTH     = ADDSUB_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_result,
  input  logic [WIDTH-1:0]     in_dataa,
  input  logic                 in_add_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_datab,
  output logic                 out_err,
  output logic [CNT_WIDTH-1:0] txn_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam int TW = 2 * WIDTH + 2;

  logic          s1_valid;
  logic          s2_in_ready;
  logic [TW-1:0] s1_data;
  logic [WIDTH:0]   s1_result;
  logic [WIDTH-1:0] s1_dataa;
  logic             s1_add_sub;
  logic [WIDTH:0]   d;
  logic             out_xfer;

  addsub_pipe_stage #(.DW(TW)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_result, in_dataa, in_add_sub}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign {s1_result, s1_dataa, s1_add_sub} = s1_data;

  // Bit WIDTH of the modular difference is set exactly when no WIDTH-bit datab fits.
  always_comb begin
    d = '0;
    if (s1_add_sub) d = s1_result - {1'b0, s1_dataa};
    else            d = {1'b0, s1_dataa} - s1_result;
  end

  addsub_pipe_stage #(.DW(WIDTH + 1)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_err, out_datab})
  );

  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txn_count <= '0;
      err_count <= '0;
    end else if (out_xfer) begin
      if (txn_count != '1)            txn_count <= txn_count + 1'b1;
      if (out_err && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_addsub_operand_recover.sv
// Directed and closed-loop checks of addsub_operand_recover against the forward add/sub model.
module tb_addsub_operand_recover;
  import addsub_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready4;
  logic [8:0]  in_result = '0;
  logic [7:0]  in_dataa = '0;
  logic        in_add_sub = 1'b0;
  logic        out_valid, out_valid4;
  logic        out_ready = 1'b1;
  logic [7:0]  out_datab, out_datab4;
  logic        out_err, out_err4;
  logic [15:0] txn_count, err_count;
  logic [3:0]  txn_count4, err_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_operand_recover #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dataa(in_dataa), .in_add_sub(in_add_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_datab(out_datab),
    .out_err(out_err), .txn_count(txn_count), .err_count(err_count)
  );

  addsub_operand_recover #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_result(in_result), .in_dataa(in_dataa), .in_add_sub(in_add_sub),
    .out_valid(out_valid4), .out_ready(out_ready), .out_datab(out_datab4),
    .out_err(out_err4), .txn_count(txn_count4), .err_count(err_count4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] res, input logic [7:0] a, input logic as);
    in_valid   = 1'b1;
    in_result  = res;
    in_dataa   = a;
    in_add_sub = as;
  endtask

  // One tuple through an idle pipe with out_ready held high.
  task automatic send_and_check(input string tag, input logic [8:0] res, input logic [7:0] a,
                                input logic as, input logic [7:0] exp_b, input logic exp_e);
    out_ready = 1'b1;
    drive(res, a, as);
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    check({tag, "_valid_c1"}, out_valid, 0);
    tick();
    check({tag, "_valid_c2"}, out_valid, 1);
    check({tag, "_datab"}, out_datab, exp_b);
    check({tag, "_err"}, out_err, exp_e);
    tick();
    check({tag, "_valid_after"}, out_valid, 0);
  endtask

  initial begin : stim
    logic [7:0] exp_b [5];
    logic [7:0] ta, tb;
    logic       tas;
    logic       in_fire, out_fire;
    logic [7:0] q [$];
    logic [7:0] popped;
    int         sent, got;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_datab", out_datab, 0);
    check("rst_out_err", out_err, 0);
    check("rst_txn", txn_count, 0);
    check("rst_err_cnt", err_count, 0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Directed vectors
    send_and_check("add", 9'h0C8, 8'h64, 1'b1, 8'h64, 1'b0);
    check("add_txn", txn_count, 1);
    send_and_check("sub_borrow", 9'h1F6, 8'h05, 1'b0, 8'h0F, 1'b0);
    check("sub_txn", txn_count, 2);
    check("sub_err_cnt", err_count, 0);
    send_and_check("incons", 9'h1FF, 8'h00, 1'b1, 8'hFF, 1'b1);
    check("incons_txn", txn_count, 3);
    check("incons_err_cnt", err_count, 1);

    // Backpressure: 5 back-to-back tuples, out_ready low for cycles 2..4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sent = 0;
    got  = 0;
    for (int i = 0; i < 5; i++) exp_b[i] = 8'(i * 7 + 1);
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (sent < 5) drive(addsub_fwd(8'(sent * 16 + 3), exp_b[sent], 1'b1), 8'(sent * 16 + 3), 1'b1);
      else          in_valid = 1'b0;
      #1;
      if (cyc == 1) check("bp_in_ready_s1_full", in_ready, 1);
      if (cyc == 2) check("bp_in_ready_both_full", in_ready, 0);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        check("bp_order_datab", out_datab, exp_b[got]);
        got++;
      end
      tick();
      if (in_fire) sent++;
    end
    in_valid = 1'b0;
    check("bp_outputs_seen", got, 5);
    check("bp_txn", txn_count, 5);
    check("bp_err_cnt", err_count, 0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(9'h011, 8'h10, 1'b1);
    tick();
    drive(9'h022, 8'h20, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    check("mid_full_valid", out_valid, 1);
    check("mid_full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_txn", txn_count, 0);
    check("mid_rst_err_cnt", err_count, 0);
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    send_and_check("post_rst", 9'h0A0, 8'h30, 1'b1, 8'h70, 1'b0);
    check("post_rst_txn", txn_count, 1);

    // Closed loop against the forward model, random backpressure
    sent = 0;
    got  = 0;
    ta   = 8'($urandom_range(255));
    tb   = 8'($urandom_range(255));
    tas  = 1'($urandom_range(1));
    for (int cyc = 0; cyc < 40000 && got < 10000; cyc++) begin
      out_ready = ($urandom_range(3) != 0);
      if (sent < 10000) drive(addsub_fwd(ta, tb, tas), ta, tas);
      else              in_valid = 1'b0;
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      if (out_fire) begin
        if (q.size() == 0) begin
          check("loop_unexpected_output", 1, 0);
        end else begin
          popped = q.pop_front();
          check("loop_datab", out_datab, popped);
          check("loop_err", out_err, 0);
        end
        got++;
      end
      tick();
      if (in_fire) begin
        q.push_back(tb);
        sent++;
        ta  = 8'($urandom_range(255));
        tb  = 8'($urandom_range(255));
        tas = 1'($urandom_range(1));
      end
    end
    in_valid = 1'b0;
    check("loop_outputs_seen", got, 10000);
    check("loop_txn", txn_count, 10001);
    check("loop_err_cnt", err_count, 0);
    check("sat_txn4", txn_count4, 15);
    check("sat_err4", err_count4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
